// File: rtl/regfile_pkg.sv
// Shared constants and the write-port record for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_sb_popcnt.sv
// Population count of the pending-register vector.
module regfile_sb_popcnt #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with a pending-bit scoreboard, two write ports and NUM_RD read ports.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle writes to readers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [DEPTH-1:0]  wr0_hit;
  logic [DEPTH-1:0]  wr1_hit;
  logic [DEPTH-1:0]  iss_hit;
  logic [ADDR_W:0]   pend_cnt_next;
  logic [ADDR_W:0]   pend_cnt_reg;

  // Bit 0 of every hit vector stays low, so register 0 is never written or pending.
  always_comb begin
    wr0_hit = '0;
    wr1_hit = '0;
    iss_hit = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr0_hit[i] = we0    && (waddr0   == ADDR_W'(i));
      wr1_hit[i] = we1    && (waddr1   == ADDR_W'(i));
      iss_hit[i] = iss_en && (iss_addr == ADDR_W'(i));
    end
  end

  // A same-cycle issue re-arms the bit after the write clears it (new producer).
  assign pend_next = (pend_reg & ~(wr0_hit | wr1_hit)) | iss_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr1_hit[i]) begin
          mem_reg[i] <= wdata1;
        end else if (wr0_hit[i]) begin
          mem_reg[i] <= wdata0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg     <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pend_reg     <= pend_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  regfile_sb_popcnt #(
    .W  (DEPTH),
    .CW (ADDR_W + 1)
  ) u_popcnt (
    .bits  (pend_next),
    .count (pend_cnt_next)
  );

  assign pend_cnt = pend_cnt_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] data_reg;
    logic              busy_next;
    logic              busy_reg;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      data_next = mem_reg[addr];
      busy_next = pend_reg[addr];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr1_hit[addr]) begin
        data_next = wdata1;
        busy_next = iss_hit[addr];
      end else if (wr0_hit[addr]) begin
        data_next = wdata0;
        busy_next = iss_hit[addr];
      end
`endif
      if (!rd_en[gi]) begin
        data_next = '0;
        busy_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_reg <= '0;
        busy_reg <= 1'b0;
      end else begin
        data_reg <= data_next;
        busy_reg <= busy_next;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
    assign rd_busy[gi]                  = busy_reg;
  end

endmodule
